// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-side controller.
package regfile_pkg;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_W_DEF-1:0] addr;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// ALU writeback FIFO with an age-ordered entry view (index 0 = oldest)
// for forwarding, plus squash-by-address used when a load overwrites a target.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [ADDR_W_DEF-1:0] squash_addr,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t             head,
  output wb_entry_t             view [DEPTH]
);
  localparam int unsigned PW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [PW:0]   count;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign head  = mem[rd_ptr[PW-1:0]];

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      view[i] = mem[rd_ptr[PW-1:0] + PW'(i)];
      if ((PW+1)'(i) >= count) view[i].valid = 1'b0;
    end
  end

  // Squash runs before the push write so a freshly pushed slot keeps its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
    end else begin
      if (squash) begin
        for (int unsigned i = 0; i < DEPTH; i++)
          if (mem[i].addr == squash_addr) mem[i].valid <= 1'b0;
      end
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= push_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port owner: zero-initialises x1..x31, then merges the
// load stream (priority) with the buffered ALU stream, forwarding pending data.
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [XLEN-1:0]   ld_data,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [XLEN-1:0]   r1_in,
  input  logic [XLEN-1:0]   r2_in,
  output logic [XLEN-1:0]   r1,
  output logic [XLEN-1:0]   r2,
  output logic [ADDR_W-1:0] a3,
  output logic [XLEN-1:0]   di3,
  output logic              we3,
  output logic              init_busy
);
  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic              ld_take;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  wb_entry_t         head;
  wb_entry_t         view [DEPTH];

  assign ld_take  = (state == ST_RUN) && ld_valid && (ld_addr != '0);
  assign wb_ready = (state == ST_RUN) && !full && !reset;
  assign push     = wb_valid && wb_ready && (wb_addr != '0);
  assign pop      = (state == ST_RUN) && !ld_take && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{valid: 1'b1, addr: wb_addr, data: wb_data}),
    .pop        (pop),
    .squash     (ld_take),
    .squash_addr(ld_addr),
    .full       (full),
    .empty      (empty),
    .head       (head),
    .view       (view)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      counter   <= ADDR_W'(1);
      init_busy <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          counter <= counter + 1'b1;
          if (counter == '1) begin
            state     <= ST_RUN;
            init_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Write port is idle while reset is held so no pending entry commits.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    di3 = '0;
    if (!reset) begin
      if (state == ST_INIT) begin
        we3 = 1'b1;
        a3  = counter;
      end else if (ld_take) begin
        we3 = 1'b1;
        a3  = ld_addr;
        di3 = ld_data;
      end else if (!empty && head.valid) begin
        we3 = 1'b1;
        a3  = head.addr;
        di3 = head.data;
      end
    end
  end

  // Later (younger) matches override earlier ones; the load overrides the FIFO.
  always_comb begin
    r1 = r1_in;
    r2 = r2_in;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (view[i].valid && view[i].addr == a1) r1 = view[i].data;
      if (view[i].valid && view[i].addr == a2) r2 = view[i].data;
    end
    if (ld_take && ld_addr == a1) r1 = ld_data;
    if (ld_take && ld_addr == a2) r2 = ld_data;
    if (a1 == '0) r1 = r1_in;
    if (a2 == '0) r2 = r2_in;
    if (state == ST_INIT) begin
      r1 = '0;
      r2 = '0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: hand-derived vector table plus an ALU commit scoreboard.
module tb_regfile_writeback;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wb_valid, wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [XLEN-1:0]   ld_data;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [XLEN-1:0]   r1_in, r2_in, r1, r2, di3;
  logic              we3, init_busy;

  always #5 clk = ~clk;

  regfile_writeback #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .a1(a1), .a2(a2), .r1_in(r1_in), .r2_in(r2_in), .r1(r1), .r2(r2),
    .a3(a3), .di3(di3), .we3(we3), .init_busy(init_busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic wv; logic [4:0] wa; logic [31:0] wd;
    logic lv; logic [4:0] la; logic [31:0] ld;
    logic [4:0] a1; logic [31:0] r1i; logic [4:0] a2; logic [31:0] r2i;
    logic e_rdy; logic e_we; logic [4:0] e_a3; logic [31:0] e_di3;
    logic [31:0] e_r1; logic [31:0] e_r2;
  } vec_t;

  typedef struct { logic [4:0] a; logic [31:0] d; } commit_t;

  vec_t    main_vecs[$];
  vec_t    pre_reset_vecs[$];
  commit_t sb[$];

  function automatic vec_t mk(int wv, int wa, int wd, int lv, int la, int ld,
                              int va1, int r1i, int va2, int r2i,
                              int rdy, int we, int ea3, int edi3, int er1, int er2);
    vec_t v;
    v.wv = 1'(wv); v.wa = 5'(wa); v.wd = 32'(wd);
    v.lv = 1'(lv); v.la = 5'(la); v.ld = 32'(ld);
    v.a1 = 5'(va1); v.r1i = 32'(r1i); v.a2 = 5'(va2); v.r2i = 32'(r2i);
    v.e_rdy = 1'(rdy); v.e_we = 1'(we); v.e_a3 = 5'(ea3); v.e_di3 = 32'(edi3);
    v.e_r1 = 32'(er1); v.e_r2 = 32'(er2);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    commit_t c;
    wb_valid = v.wv; wb_addr = v.wa; wb_data = v.wd;
    ld_valid = v.lv; ld_addr = v.la; ld_data = v.ld;
    a1 = v.a1; r1_in = v.r1i; a2 = v.a2; r2_in = v.r2i;
    @(negedge clk);
    chk({tag, "_wb_ready"}, 32'(wb_ready), 32'(v.e_rdy));
    chk({tag, "_we3"}, 32'(we3), 32'(v.e_we));
    chk({tag, "_a3"}, 32'(a3), 32'(v.e_a3));
    chk({tag, "_di3"}, di3, v.e_di3);
    chk({tag, "_r1"}, r1, v.e_r1);
    chk({tag, "_r2"}, r2, v.e_r2);
    if (we3 === 1'b1 && !(v.lv && v.la != 0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb_spurious: got write a3=%0d di3=%0h expected no ALU commit", tag, a3, di3);
      end else begin
        c = sb.pop_front();
        chk({tag, "_sb_a3"}, 32'(a3), 32'(c.a));
        chk({tag, "_sb_di3"}, di3, c.d);
      end
    end
    if (v.lv && v.la != 0) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].a == v.la) sb.delete(i);
    end
    if (v.wv && wb_ready === 1'b1 && v.wa != 0) begin
      c.a = v.wa;
      c.d = v.wd;
      sb.push_back(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_init(input string tag);
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      chk($sformatf("%s_init%0d_we3", tag, k), 32'(we3), 32'd1);
      chk($sformatf("%s_init%0d_a3", tag, k), 32'(a3), 32'(k));
      chk($sformatf("%s_init%0d_di3", tag, k), di3, 32'd0);
      chk($sformatf("%s_init%0d_busy", tag, k), 32'(init_busy), 32'd1);
      chk($sformatf("%s_init%0d_wb_ready", tag, k), 32'(wb_ready), 32'd0);
      chk($sformatf("%s_init%0d_r1", tag, k), r1, 32'd0);
      chk($sformatf("%s_init%0d_r2", tag, k), r2, 32'd0);
      @(posedge clk); #1;
    end
    wb_valid = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_run_busy"}, 32'(init_busy), 32'd0);
    chk({tag, "_run_wb_ready"}, 32'(wb_ready), 32'd1);
    chk({tag, "_run_we3"}, 32'(we3), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    //                wv wa  wd   lv la ld   a1 r1i a2 r2i rdy we a3 di3 r1  r2
    main_vecs.push_back(mk(1, 5, 69,  0, 0, 0,  5, 0,  0, 7,  1, 0, 0, 0,  0,  7));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  5, 0,  5, 3,  1, 1, 5, 69, 69, 69));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  5, 11, 0, 0,  1, 0, 0, 0,  11, 0));
    main_vecs.push_back(mk(1, 1, 1,   1, 7, 70, 7, 0,  1, 0,  1, 1, 7, 70, 70, 0));
    main_vecs.push_back(mk(1, 2, 2,   1, 7, 71, 1, 0,  2, 0,  1, 1, 7, 71, 1,  0));
    main_vecs.push_back(mk(1, 3, 3,   1, 7, 72, 2, 0,  1, 0,  0, 1, 7, 72, 2,  1));
    main_vecs.push_back(mk(1, 3, 3,   0, 0, 0,  1, 0,  2, 0,  0, 1, 1, 1,  1,  2));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  1, 0,  2, 0,  1, 1, 2, 2,  0,  2));
    main_vecs.push_back(mk(1, 9, 10,  1, 7, 73, 9, 0,  0, 0,  1, 1, 7, 73, 0,  0));
    main_vecs.push_back(mk(0, 0, 0,   1, 9, 20, 9, 0,  9, 5,  1, 1, 9, 20, 20, 20));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  9, 20, 9, 20, 1, 0, 0, 0,  20, 20));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  9, 20, 0, 0,  1, 0, 0, 0,  20, 0));
    main_vecs.push_back(mk(1, 0, 123, 1, 0, 5,  0, 44, 0, 55, 1, 0, 0, 0,  44, 55));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  0, 45, 0, 46, 1, 0, 0, 0,  45, 46));
    main_vecs.push_back(mk(1, 4, 40,  1, 6, 60, 4, 1,  6, 2,  1, 1, 6, 60, 1,  60));
    main_vecs.push_back(mk(1, 4, 41,  0, 0, 0,  4, 1,  0, 2,  1, 1, 4, 40, 40, 2));
    main_vecs.push_back(mk(1, 4, 42,  1, 8, 80, 4, 1,  8, 0,  1, 1, 8, 80, 41, 80));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  4, 1,  4, 1,  0, 1, 4, 41, 42, 42));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  4, 1,  0, 9,  1, 1, 4, 42, 42, 9));
    main_vecs.push_back(mk(0, 0, 0,   0, 0, 0,  4, 42, 0, 0,  1, 0, 0, 0,  42, 0));
    pre_reset_vecs.push_back(mk(1, 10, 100, 1, 7, 1, 0,  0, 0,  0, 1, 1, 7, 1, 0,   0));
    pre_reset_vecs.push_back(mk(1, 11, 110, 1, 7, 2, 10, 0, 11, 0, 1, 1, 7, 2, 100, 0));

    reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    a1 = '0; a2 = '0; r1_in = '0; r2_in = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_busy", 32'(init_busy), 32'd1);
    chk("reset_we3", 32'(we3), 32'd0);
    chk("reset_wb_ready", 32'(wb_ready), 32'd0);
    @(posedge clk); #1;

    // INIT with an ALU request and a load held: both must be ignored.
    reset = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'd99;
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'd33;
    a1 = 5'd3; r1_in = 32'h1111; a2 = 5'd4; r2_in = 32'h2222;
    check_init("boot");

    foreach (main_vecs[i]) run_vec(main_vecs[i], $sformatf("v%0d", i));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    foreach (pre_reset_vecs[i]) run_vec(pre_reset_vecs[i], $sformatf("p%0d", i));

    // Reset with two ALU writes pending: they must never commit.
    reset = 1'b1; wb_valid = 1'b0; ld_valid = 1'b0;
    a1 = 5'd11; r1_in = 32'h5; a2 = 5'd10; r2_in = 32'h6;
    @(negedge clk);
    chk("midreset_we3", 32'(we3), 32'd0);
    chk("midreset_wb_ready", 32'(wb_ready), 32'd0);
    @(posedge clk); #1;
    sb.delete();
    reset = 1'b0;
    check_init("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
